// File: rtl/usb_tx_pkg.sv
// Shared types and constants for the USB transmit encoder.
// Line levels are packed as {dp, dm}.
package usb_tx_pkg;

  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned BIT_CNT_W = 4;
  localparam int unsigned ONES_W    = 3;
  localparam int unsigned STAT_W    = 8;

  // Number of consecutive ones that forces a stuff bit
  localparam logic [ONES_W-1:0] STUFF_LIMIT = ONES_W'(6);

  typedef logic [1:0] line_t;
  localparam line_t LINE_J   = 2'b10;
  localparam line_t LINE_K   = 2'b01;
  localparam line_t LINE_SE0 = 2'b00;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_STUFF,
    ST_EOP_SE0,
    ST_EOP_J
  } tx_state_t;

  typedef enum logic [1:0] {
    NRZI_HOLD,
    NRZI_TOGGLE,
    NRZI_SE0,
    NRZI_J
  } nrzi_cmd_t;

  // What the encoder does on the current bit strobe
  typedef enum logic [2:0] {
    ACT_IDLE,
    ACT_LOAD,
    ACT_DATA,
    ACT_STUFF,
    ACT_EOP,
    ACT_ABORT,
    ACT_SE0,
    ACT_EOP_J
  } tx_act_t;

  typedef struct packed {
    logic              last;
    logic [BYTE_W-1:0] data;
  } tx_byte_t;

endpackage

// File: rtl/usb_tx_nrzi.sv
// NRZI line-level register: holds, toggles J/K, or forces SE0/J on each strobe.
// Ports: clk, n_rst (sync active-low), strobe (bit tick), cmd (action), dp/dm (line).
module usb_tx_nrzi
  import usb_tx_pkg::*;
(
  input  logic      clk,
  input  logic      n_rst,
  input  logic      strobe,
  input  nrzi_cmd_t cmd,
  output logic      dp,
  output logic      dm
);

  line_t level;

  // Level only moves on a bit strobe; a toggle from anything but J lands on J
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      level <= LINE_J;
    end else if (strobe) begin
      case (cmd)
        NRZI_HOLD:   level <= level;
        NRZI_TOGGLE: level <= (level == LINE_J) ? LINE_K : LINE_J;
        NRZI_SE0:    level <= LINE_SE0;
        NRZI_J:      level <= LINE_J;
        default:     level <= level;
      endcase
    end
  end

  assign dp = level[1];
  assign dm = level[0];

endmodule

// File: rtl/usb_tx_encoder.sv
// USB transmit encoder: byte holding register, LSB-first shifter, bit stuffing,
// NRZI encoding and EOP generation, all advancing on bit_strobe.
// Ports: clk, n_rst (sync active-low), bit_strobe, tx_data/tx_valid/tx_last/tx_ready
// (byte input handshake), dp/dm (line), busy, underrun (one-cycle pulse).
// Optional: define USB_TX_ENCODER_STATS_EN to add stuff_count (saturating stuff-bit count).
module usb_tx_encoder
  import usb_tx_pkg::*;
(
  input  logic              clk,
  input  logic              n_rst,
  input  logic              bit_strobe,
  input  logic [BYTE_W-1:0] tx_data,
  input  logic              tx_valid,
  input  logic              tx_last,
  output logic              tx_ready,
  output logic              dp,
  output logic              dm,
  output logic              busy,
  output logic              underrun
`ifdef USB_TX_ENCODER_STATS_EN
  ,
  output logic [STAT_W-1:0] stuff_count
`endif
);

  tx_state_t              state;
  tx_byte_t               hold;
  logic                   hold_full;
  logic [BYTE_W-1:0]      shift_reg;
  logic                   cur_last;
  logic [BIT_CNT_W-1:0]   bit_cnt;
  logic [ONES_W-1:0]      ones_cnt;
  logic                   eop_second;
  logic                   eop_lock;

  tx_act_t                act_c;
  logic                   tx_bit_c;
  nrzi_cmd_t              nrzi_cmd_c;
  logic                   accept_c;

  // The holding register also stays closed from a last byte until the packet ends
  assign tx_ready = !(hold_full || eop_lock);
  assign accept_c = tx_valid && tx_ready;

  // Decide what the next strobe does; stuffing takes priority over data and EOP
  always_comb begin
    act_c = ACT_IDLE;
    case (state)
      ST_IDLE: act_c = hold_full ? ACT_LOAD : ACT_IDLE;
      ST_SHIFT, ST_STUFF: begin
        if (ones_cnt == STUFF_LIMIT)                  act_c = ACT_STUFF;
        else if (bit_cnt != BIT_CNT_W'(BYTE_W))       act_c = ACT_DATA;
        else if (cur_last)                            act_c = ACT_EOP;
        else if (hold_full)                           act_c = ACT_LOAD;
        else                                          act_c = ACT_ABORT;
      end
      ST_EOP_SE0: act_c = eop_second ? ACT_EOP_J : ACT_SE0;
      ST_EOP_J:   act_c = ACT_IDLE;
      default:    act_c = ACT_IDLE;
    endcase
  end

  // Bit on the wire this strobe and the matching NRZI command
  always_comb begin
    tx_bit_c   = (act_c == ACT_LOAD) ? hold.data[0] : shift_reg[bit_cnt[2:0]];
    nrzi_cmd_c = NRZI_J;
    case (act_c)
      ACT_LOAD, ACT_DATA:          nrzi_cmd_c = tx_bit_c ? NRZI_HOLD : NRZI_TOGGLE;
      ACT_STUFF:                   nrzi_cmd_c = NRZI_TOGGLE;
      ACT_EOP, ACT_ABORT, ACT_SE0: nrzi_cmd_c = NRZI_SE0;
      default:                     nrzi_cmd_c = NRZI_J;
    endcase
  end

  // Control FSM, holding/shift registers and status outputs
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state      <= ST_IDLE;
      hold       <= '0;
      hold_full  <= 1'b0;
      shift_reg  <= '0;
      cur_last   <= 1'b0;
      bit_cnt    <= '0;
      ones_cnt   <= '0;
      eop_second <= 1'b0;
      eop_lock   <= 1'b0;
      busy       <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      underrun <= 1'b0;
      if (bit_strobe) begin
        case (act_c)
          ACT_LOAD: begin
            shift_reg <= hold.data;
            cur_last  <= hold.last;
            hold_full <= 1'b0;
            bit_cnt   <= BIT_CNT_W'(1);
            ones_cnt  <= tx_bit_c ? ones_cnt + ONES_W'(1) : '0;
            state     <= ST_SHIFT;
          end
          ACT_DATA: begin
            bit_cnt  <= bit_cnt + BIT_CNT_W'(1);
            ones_cnt <= tx_bit_c ? ones_cnt + ONES_W'(1) : '0;
            state    <= ST_SHIFT;
          end
          ACT_STUFF: begin
            ones_cnt <= '0;
            state    <= ST_STUFF;
          end
          ACT_EOP, ACT_ABORT: begin
            underrun   <= (act_c == ACT_ABORT);
            ones_cnt   <= '0;
            bit_cnt    <= '0;
            eop_second <= 1'b0;
            state      <= ST_EOP_SE0;
          end
          ACT_SE0: eop_second <= 1'b1;
          ACT_EOP_J: begin
            eop_second <= 1'b0;
            state      <= ST_EOP_J;
          end
          default: begin
            if (state == ST_EOP_J) begin
              state    <= ST_IDLE;
              busy     <= 1'b0;
              eop_lock <= 1'b0;
            end
          end
        endcase
      end
      // Byte intake comes last so a new packet's busy/lock win over EOP completion
      if (accept_c) begin
        hold.data <= tx_data;
        hold.last <= tx_last;
        hold_full <= 1'b1;
        busy      <= 1'b1;
        if (tx_last) eop_lock <= 1'b1;
      end
    end
  end

`ifdef USB_TX_ENCODER_STATS_EN
  // Cumulative, saturating count of inserted stuff bits
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      stuff_count <= '0;
    end else if (bit_strobe && (act_c == ACT_STUFF) && (stuff_count != '1)) begin
      stuff_count <= stuff_count + STAT_W'(1);
    end
  end
`endif

  usb_tx_nrzi u_nrzi (
    .clk    (clk),
    .n_rst  (n_rst),
    .strobe (bit_strobe),
    .cmd    (nrzi_cmd_c),
    .dp     (dp),
    .dm     (dm)
  );

endmodule

// File: tb/tb_usb_tx_encoder.sv
// Self-checking bench for usb_tx_encoder: a packet-level model turns a byte list into
// the expected per-strobe line levels; one checker compares the line, busy, underrun
// and tx_ready every cycle. Honours USB_TX_ENCODER_STATS_EN for stuff_count.
module tb_usb_tx_encoder;

  localparam logic [1:0] L_J   = 2'b10;
  localparam logic [1:0] L_K   = 2'b01;
  localparam logic [1:0] L_SE0 = 2'b00;
  localparam int F_UNDER = 4;
  localparam int F_END   = 8;

  logic       clk;
  logic       n_rst;
  logic       bit_strobe;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_last;
  logic       tx_ready;
  logic       dp;
  logic       dm;
  logic       busy;
  logic       underrun;
`ifdef USB_TX_ENCODER_STATS_EN
  logic [7:0] stuff_count;
  int         stat_exp;
  int         pkt_nst;
  int         cur_nst;
`endif

  usb_tx_encoder dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .bit_strobe (bit_strobe),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_last    (tx_last),
    .tx_ready   (tx_ready),
    .dp         (dp),
    .dm         (dm),
    .busy       (busy),
    .underrun   (underrun)
`ifdef USB_TX_ENCODER_STATS_EN
    ,
    .stuff_count(stuff_count)
`endif
  );

  int n_cmp = 0;
  int n_fail = 0;

  // Model state shared between driver and checker
  int         mdl_q[$];
  int         mdl_nst;
  int         pkt_q[$];
  int         exp_q[$];
  bit         pkt_armed = 0;
  time        pkt_time = 0;
  bit         busy_exp = 0;
  bit         lock_exp = 0;
  bit         chk_en = 0;
  logic [1:0] cur_line = L_J;
  int         pop_cnt = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One-cycle strobe every 4 clocks
  initial begin
    int sc;
    sc = 0;
    bit_strobe = 1'b0;
    forever begin
      @(negedge clk);
      bit_strobe = (sc == 3);
      sc = (sc + 1) % 4;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
    end
  endtask

  function automatic logic [1:0] flip(input logic [1:0] l);
    return (l == L_J) ? L_K : L_J;
  endfunction

  // Packet model: bits LSB first, a 0 inserted after every run of six 1s,
  // NRZI from J, then SE0 SE0 J and the strobe that returns to idle.
  function automatic void build_model(input logic [7:0] b[$], input bit is_last);
    logic [1:0] lvl;
    int ones;
    logic bt;
    mdl_q.delete();
    mdl_nst = 0;
    lvl = L_J;
    ones = 0;
    foreach (b[i]) begin
      for (int k = 0; k < 8; k++) begin
        bt = b[i][k];
        if (!bt) lvl = flip(lvl);
        mdl_q.push_back(int'(lvl));
        ones = bt ? ones + 1 : 0;
        if (ones == 6) begin
          lvl = flip(lvl);
          mdl_q.push_back(int'(lvl));
          ones = 0;
          mdl_nst++;
        end
      end
    end
    mdl_q.push_back(is_last ? int'(L_SE0) : (int'(L_SE0) | F_UNDER));
    mdl_q.push_back(int'(L_SE0));
    mdl_q.push_back(int'(L_J));
    mdl_q.push_back(int'(L_J) | F_END);
  endfunction

  task automatic pin(input string name, input logic [7:0] b[$], input bit is_last, input string want);
    string s;
    int e;
    build_model(b, is_last);
    s = "";
    foreach (mdl_q[i]) begin
      e = mdl_q[i];
      case (e[1:0])
        L_J:     s = {s, "J"};
        L_K:     s = {s, "K"};
        default: s = {s, "0"};
      endcase
    end
    n_cmp++;
    if (s != want) begin
      n_fail++;
      $display("FAIL pin_%s: got %s expected %s", name, s, want);
    end
  endtask

  // Per-cycle checker, sampling 1 time unit after each rising edge
  initial begin
    bit  stb;
    time edge_t;
    int  e;
    bit  und_exp;
    forever begin
      @(posedge clk);
      stb = bit_strobe;
      edge_t = $time;
      #1;
      if (chk_en) begin
        und_exp = 1'b0;
        if (stb) begin
          if (exp_q.size() == 0 && pkt_armed && pkt_time < edge_t) begin
            exp_q = pkt_q;
            pkt_armed = 0;
            pop_cnt = 0;
`ifdef USB_TX_ENCODER_STATS_EN
            cur_nst = pkt_nst;
`endif
          end
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            pop_cnt++;
            cur_line = e[1:0];
            und_exp = e[2];
            if (e[3]) begin
              busy_exp = 0;
              lock_exp = 0;
`ifdef USB_TX_ENCODER_STATS_EN
              stat_exp = (stat_exp + cur_nst > 255) ? 255 : stat_exp + cur_nst;
              chk("stuff_count", 32'(stuff_count), 32'(stat_exp));
`endif
            end
          end else begin
            cur_line = L_J;
          end
        end
        chk("line", 32'({dp, dm}), 32'(cur_line));
        chk("underrun", 32'(underrun), 32'(und_exp));
        chk("busy", 32'(busy), 32'(busy_exp));
        if (lock_exp) chk("tx_ready_locked", 32'(tx_ready), 32'd0);
        else if (!busy_exp) chk("tx_ready_idle", 32'(tx_ready), 32'd1);
      end
    end
  end

  // Offer one byte until accepted (bounded); updates the model's accept-side state
  task automatic push_byte(input logic [7:0] d, input bit last, input bit first);
    bit acc;
    bit rdy;
    @(negedge clk);
    tx_data = d;
    tx_valid = 1'b1;
    tx_last = last;
    acc = 0;
    for (int w = 0; w < 300 && !acc; w++) begin
      rdy = tx_ready;
      @(posedge clk);
      if (rdy) begin
        acc = 1;
        busy_exp = 1;
        if (last) lock_exp = 1;
        if (first) begin
          pkt_armed = 1;
          pkt_time = $time;
        end
      end else begin
        @(negedge clk);
      end
    end
    chk("accept", 32'(acc), 32'd1);
    @(negedge clk);
    tx_valid = 1'b0;
    tx_last = 1'b0;
  endtask

  task automatic send_packet(input logic [7:0] b[$], input bit is_last);
    bit pending;
    build_model(b, is_last);
    pkt_q = mdl_q;
`ifdef USB_TX_ENCODER_STATS_EN
    pkt_nst = mdl_nst;
`endif
    foreach (b[i]) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      push_byte(b[i], is_last && (i == b.size() - 1), i == 0);
    end
    pending = 1;
    for (int w = 0; w < 3000 && pending; w++) begin
      @(negedge clk);
      pending = busy_exp || pkt_armed || (exp_q.size() != 0);
    end
    chk("drain", 32'(pending), 32'd0);
    repeat ($urandom_range(0, 6)) @(negedge clk);
  endtask

  initial begin
    logic [7:0] bq[$];
    int e;
    bit reached;
    n_rst = 1'b0;
    tx_data = 8'h00;
    tx_valid = 1'b0;
    tx_last = 1'b0;
`ifdef USB_TX_ENCODER_STATS_EN
    stat_exp = 0;
    pkt_nst = 0;
    cur_nst = 0;
`endif

    // Hand-derived sequences that pin the model
    bq = {8'h80};        pin("80", bq, 1, "KJKJKJKK00JJ");
    bq = {8'hFF};        pin("FF", bq, 1, "JJJJJJKKK00JJ");
    bq = {8'hF0, 8'h03}; pin("F0_03", bq, 1, "KJKJJJJJJJKJKJKJK00JJ");
    bq = {8'h00};        pin("00_under", bq, 0, "KJKJKJKJ00JJ");
    e = mdl_q[8];
    chk("pin_under_flag", 32'(e[2]), 32'd1);
    bq = {8'hFF, 8'hFF}; build_model(bq, 1);
    chk("pin_nst_FFFF", 32'(mdl_nst), 32'd2);

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_line", 32'({dp, dm}), 32'(L_J));
    chk("rst_ready", 32'(tx_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_underrun", 32'(underrun), 32'd0);
`ifdef USB_TX_ENCODER_STATS_EN
    chk("rst_stuff_count", 32'(stuff_count), 32'd0);
`endif
    n_rst = 1'b1;
    chk_en = 1;
    repeat (5) @(negedge clk);

    // Directed packets
    bq = {8'h80};        send_packet(bq, 1);
    bq = {8'hFF};        send_packet(bq, 1);
    bq = {8'hF0, 8'h03}; send_packet(bq, 1);
    bq = {8'hFF, 8'hFF}; send_packet(bq, 1);
    bq = {8'h00};        send_packet(bq, 0);

    // Randomized packets, biased towards long runs of ones
    for (int p = 0; p < 40; p++) begin
      int n;
      bq.delete();
      n = $urandom_range(1, 4);
      for (int i = 0; i < n; i++) begin
        case ($urandom_range(0, 3))
          0: bq.push_back(8'hFF);
          1: bq.push_back(8'(8'hF0 | 8'($urandom_range(0, 15))));
          default: bq.push_back(8'($urandom_range(0, 255)));
        endcase
      end
      send_packet(bq, $urandom_range(0, 4) != 0);
    end

    // Reset during bit 3 of a byte
    bq = {8'h55};
    build_model(bq, 1);
    pkt_q = mdl_q;
    pop_cnt = 0;
    push_byte(8'h55, 1, 1);
    reached = 0;
    for (int w = 0; w < 200 && !reached; w++) begin
      @(negedge clk);
      reached = (pop_cnt >= 4) && !pkt_armed;
    end
    chk("reach_bit3", 32'(reached), 32'd1);
    n_rst = 1'b0;
    chk_en = 0;
    @(posedge clk);
    #1;
    chk("mid_rst_line", 32'({dp, dm}), 32'(L_J));
    chk("mid_rst_ready", 32'(tx_ready), 32'd1);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_underrun", 32'(underrun), 32'd0);
`ifdef USB_TX_ENCODER_STATS_EN
    chk("mid_rst_stuff_count", 32'(stuff_count), 32'd0);
    stat_exp = 0;
`endif
    @(negedge clk);
    n_rst = 1'b1;
    exp_q.delete();
    pkt_armed = 0;
    busy_exp = 0;
    lock_exp = 0;
    cur_line = L_J;
    chk_en = 1;
    repeat (60) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, %0d compared", n_cmp);
    $fatal(1);
  end

endmodule

// File: doc/usb_tx_encoder.md
USB_TX_ENCODER -- requirements
Module: usb_tx_encoder

Interface
REQ-001 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-002 SHALL have port n_rst, input, 1, synchronous active-low reset.
REQ-003 SHALL have port bit_strobe, input, 1, one-cycle bit-period tick from the upstream TX bit-rate counter rollover flag.
REQ-004 SHALL have port tx_data, input, 8, packet byte, sent LSB first.
REQ-005 SHALL have port tx_valid, input, 1, tx_data valid.
REQ-006 SHALL have port tx_last, input, 1, qualifies tx_data as the final byte of the packet.
REQ-007 SHALL have port tx_ready, output, 1, holding register empty; a byte is accepted on any cycle with tx_valid && tx_ready.
REQ-008 SHALL have ports dp and dm, output, 1 each, differential line: J = (1,0), K = (0,1), SE0 = (0,0).
REQ-009 SHALL have port busy, output, 1, high from first accepted byte until EOP J completes.
REQ-010 SHALL have port underrun, output, 1, one-cycle pulse on a data underrun.

Function
REQ-011 SHALL implement the FSM states IDLE, SHIFT, STUFF, EOP_SE0, EOP_J; dp, dm and all state advance SHALL change only on cycles with bit_strobe=1.
REQ-012 SHALL hold one byte in a holding register and one in an 8-bit shift register; tx_ready is the combinational inverse of the holding-register full flag.
REQ-013 SHALL, in IDLE, drive J, and on a strobe with a full holding register, move the byte to the shift register, go to SHIFT, and emit bit 0 on that same strobe.
REQ-014 SHALL NRZI-encode the data: a 0 bit toggles J/K, and a 1 bit holds the current level.
REQ-015 SHALL count consecutive transmitted 1s. The counter clears at packet start and on every transmitted 0. After the sixth 1, the next strobe SHALL go to STUFF and emit a 0 (toggle) without consuming data, then return to SHIFT.
REQ-016 SHALL carry the ones counter across byte boundaries.
REQ-017 SHALL reload the shift register from the holding register on the strobe after bit 7 when a byte is available, with no gap bit.
REQ-018 SHALL, after bit 7 of a byte marked tx_last (including any pending stuff bit), go to EOP_SE0 for exactly 2 strobes, then EOP_J for 1 strobe, then IDLE.
REQ-019 SHALL, after bit 7 of a byte not marked tx_last when the holding register is empty, pulse underrun and go to EOP_SE0 (abort).
REQ-020 SHALL keep tx_ready low from an accepted tx_last byte until IDLE is re-entered.

Reset
REQ-021 SHALL, when n_rst=0 at a rising edge, including mid-packet, set state IDLE, dp=1, dm=0, tx_ready=1, busy=0, underrun=0, clear the holding and shift registers and the ones counter, and emit no EOP.

Configuration
REQ-022 SHALL, with USB_TX_ENCODER_STATS_EN defined, add an 8-bit output stuff_count, reset to 0, that increments once per stuff bit, saturates at 255, and is cumulative across packets.
REQ-023 SHALL, without USB_TX_ENCODER_STATS_EN defined, have no stuff_count port and no associated logic; all other behaviour is identical.

Structure
REQ-024 SHALL take the state enum and the J/K/SE0 line-level constants from shared package usb_tx_pkg.
REQ-025 SHALL place the NRZI level register and toggle/hold/force logic in sub-module usb_tx_nrzi.

Verification
REQ-026 SHALL cover: single byte 0x80 with tx_last, strobe every 4 cycles -> line KJKJKJKK, SE0, SE0, J, idle J; busy high throughout.
REQ-027 SHALL cover: single byte 0xFF with tx_last -> six holds, stuff toggle, two holds (9 bit-times), then SE0, SE0, J; stuff_count=1 when STATS_EN.
REQ-028 SHALL cover: 0xF0 then 0x03 (last) back-to-back -> stuff bit inserted after bit 1 of the second byte; no gap bit between bytes.
REQ-029 SHALL cover: 0xFF, 0xFF (last) -> stuff bits after 6th and 12th ones; stuff_count=2.
REQ-030 SHALL cover: first byte 0x00 (not last) with no second byte -> underrun pulses once after bit 7, then SE0, SE0, J.
REQ-031 SHALL cover: n_rst low during bit 3 of a byte -> next cycle J, IDLE, tx_ready=1, busy=0, and no EOP follows.
